// File: rtl/zoom_uart_pkg.sv
// Shared UART constants and types, used by both uart_tx and uart_rx.
//   tx_state_e       : transmitter FSM states (IDLE/START/DATA/STOP)
//   UART_DEFAULT_DIV : baud divisor loaded at reset, in clock cycles per bit
//   UART_DIV_MIN     : smallest divisor the baud counter accepts
package zoom_uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    localparam logic [12:0] UART_DEFAULT_DIV = 13'h1869;
    localparam int unsigned UART_DIV_MIN     = 2;

endpackage

// File: rtl/tx_byte_fifo.sv
// Synchronous byte FIFO that sits between the core's stores and the transmitter.
// Ports:
//   clk, reset       : clock, synchronous active-high reset (empties the FIFO)
//   push, wdata      : write request and byte; ignored while full
//   pop              : read request; ignored while empty
//   rdata            : head-of-queue byte (valid while !empty)
//   full, empty      : occupancy flags
//   count            : current occupancy, 0..FIFO_DEPTH
module tx_byte_fifo #(
    parameter  int FIFO_DEPTH = 4,
    localparam int AW         = $clog2(FIFO_DEPTH),
    localparam int CW         = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [7:0]    wdata,
    input  logic          pop,
    output logic [7:0]    rdata,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    // when the address bits match.
    logic [AW:0] wptr_q, wptr_d;
    logic [AW:0] rptr_q, rptr_d;
    logic [7:0]  mem_q [FIFO_DEPTH];

    logic do_push, do_pop;

    assign count   = wptr_q - rptr_q;
    assign empty   = (wptr_q == rptr_q);
    assign full    = (count == CW'(FIFO_DEPTH));
    assign rdata   = mem_q[rptr_q[AW-1:0]];

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (do_push) wptr_d = wptr_q + 1'b1;
        if (do_pop)  rptr_d = rptr_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage needs no reset; contents are only read between push and pop.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/uart_tx.sv
// Buffered 8N1 UART transmitter, LSB first.
// Ports:
//   clk, reset          : clock, synchronous active-high reset (aborts frame, flushes FIFO)
//   speed, set_speed    : new divisor (cycles per bit) written to the pending divisor
//   tx_data, tx_valid   : byte offer; accepted when tx_valid && tx_ready
//   tx_ready            : FIFO not full
//   tx                  : serial line, registered, idles high
//   busy                : frame on the line or bytes still queued
//   fifo_count          : FIFO occupancy
module uart_tx
    import zoom_uart_pkg::*;
#(
    parameter  int                   FIFO_DEPTH  = 4,
    parameter  int                   DIV_WIDTH   = 13,
    parameter  logic [DIV_WIDTH-1:0] DEFAULT_DIV = DIV_WIDTH'(UART_DEFAULT_DIV),
    localparam int                   CW          = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DIV_WIDTH-1:0] speed,
    input  logic                 set_speed,
    input  logic [7:0]           tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy,
    output logic [CW-1:0]        fifo_count
);

    localparam logic [DIV_WIDTH-1:0] DIV_MIN = DIV_WIDTH'(UART_DIV_MIN);

    tx_state_e            state_q, state_d;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;       // baud counter, DIV-1 down to 0
    logic [2:0]           bit_q, bit_d;       // data bit index
    logic [7:0]           shift_q, shift_d;
    logic [DIV_WIDTH-1:0] div_act_q, div_act_d;   // divisor of the frame on the line
    logic [DIV_WIDTH-1:0] div_pend_q, div_pend_d; // divisor for the next frame
    logic                 tx_q, tx_d;

    logic       fifo_full, fifo_empty, fifo_pop;
    logic [7:0] fifo_rdata;
    logic       tc, start_frame;

    tx_byte_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (tx_valid),
        .wdata (tx_data),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign tx_ready = !fifo_full;
    assign tx       = tx_q;
    assign busy     = (state_q != ST_IDLE) || (fifo_count != '0);

    assign tc = (cnt_q == '0);

    // A new frame begins from IDLE, or straight out of the last stop-bit
    // cycle so back-to-back bytes leave no idle gap on the line.
    assign start_frame = !fifo_empty &&
                         ((state_q == ST_IDLE) || (state_q == ST_STOP && tc));
    assign fifo_pop    = start_frame;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        div_act_d  = div_act_q;
        div_pend_d = div_pend_q;

        if (set_speed) div_pend_d = (speed < DIV_MIN) ? DIV_MIN : speed;

        case (state_q)
            ST_START: begin
                if (tc) begin
                    state_d = ST_DATA;
                    cnt_d   = div_act_q - 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DATA: begin
                if (tc) begin
                    cnt_d = div_act_q - 1'b1;
                    if (bit_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        shift_d = shift_q >> 1;
                        bit_d   = bit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_STOP: begin
                if (tc) state_d = ST_IDLE;
                else    cnt_d   = cnt_q - 1'b1;
            end
            default: ;
        endcase

        // The pending divisor (as registered before this edge) is latched only
        // here, so a set_speed mid-frame never stretches the current frame.
        if (start_frame) begin
            state_d   = ST_START;
            shift_d   = fifo_rdata;
            div_act_d = div_pend_q;
            cnt_d     = div_pend_q - 1'b1;
            bit_d     = '0;
        end

        // tx is registered from the next state, so the line changes on the
        // same edge the state does.
        case (state_d)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shift_d[0];
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            div_act_q  <= DEFAULT_DIV;
            div_pend_q <= DEFAULT_DIV;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            div_act_q  <= div_act_d;
            div_pend_q <= div_pend_d;
            tx_q       <= tx_d;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx. A frame-level reference model (byte queue,
// frame start time and per-frame divisor) predicts tx, tx_ready, busy and
// fifo_count every cycle; each scenario task compares them at the falling edge.
module tb_uart_tx;

    localparam int          DEPTH   = 4;
    localparam int          DW      = 13;
    localparam int          CW      = 3;
    localparam logic [12:0] DEF_DIV = 13'h1869;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] speed = '0;
    logic          set_speed = 1'b0;
    logic [7:0]    tx_data = '0;
    logic          tx_valid = 1'b0;
    logic          tx_ready, tx, busy;
    logic [CW-1:0] fifo_count;

    uart_tx #(.FIFO_DEPTH(DEPTH), .DIV_WIDTH(DW), .DEFAULT_DIV(DEF_DIV)) dut (
        .clk        (clk),
        .reset      (reset),
        .speed      (speed),
        .set_speed  (set_speed),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx         (tx),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;

    // Reference model state
    logic [7:0] mq[$];
    bit         m_act = 0;   // a frame is on the line
    bit         m_acc = 0;   // last edge accepted a byte
    int         m_t = 0;     // cycles since the frame's start bit began
    int         m_div = DEF_DIV;
    int         m_pend = DEF_DIV;
    logic [7:0] m_byte = '0;

    wire [5:0] dut_vec = {tx, tx_ready, busy, fifo_count};

    // {tx, tx_ready, busy, fifo_count} predicted from the frame position:
    // slot 0 = start bit, slots 1..8 = data LSB first, slot 9 = stop bit.
    function automatic logic [5:0] exp_vec();
        logic lvl;
        int   k;
        lvl = 1'b1;
        if (m_act) begin
            k = m_t / m_div;
            if (k == 0)      lvl = 1'b0;
            else if (k <= 8) lvl = m_byte[k-1];
        end
        return {lvl, mq.size() < DEPTH, m_act || mq.size() != 0, CW'(mq.size())};
    endfunction

    // Advance one clock: update the model with the inputs seen at the rising
    // edge, then return at the falling edge where outputs are sampled.
    task automatic step();
        int sz;
        bit st;
        @(posedge clk);
        m_acc = 0;
        if (reset) begin
            mq.delete();
            m_act  = 0;
            m_t    = 0;
            m_pend = DEF_DIV;
        end else begin
            sz = mq.size();
            st = 0;
            if (!m_act) st = (sz > 0);
            else if (m_t == 10 * m_div - 1) begin
                if (sz > 0) st = 1;
                else        m_act = 0;
            end
            if (st) begin
                m_byte = mq.pop_front();
                m_div  = m_pend;
                m_t    = 0;
                m_act  = 1;
            end else if (m_act) begin
                m_t++;
            end
            if (tx_valid && sz < DEPTH) begin
                mq.push_back(tx_data);
                m_acc = 1;
            end
            if (set_speed) m_pend = (speed < 2) ? 2 : int'(speed);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; tx_valid = 1'b1; tx_data = 8'h5A;
        for (int i = 0; i < 3; i++) begin
            step(); vecs++;
            if (dut_vec !== 6'b110000) begin
                errs++; $display("FAIL reset cyc%0d: got %b want %b", i, dut_vec, 6'b110000);
            end
        end
        tx_valid = 1'b0; reset = 1'b0;
        step(); vecs++;
        if (dut_vec !== exp_vec()) begin
            errs++; $display("FAIL reset_release: got %b want %b", dut_vec, exp_vec());
        end
    endtask

    task automatic set_div_and_push(input int div, input logic [7:0] b);
        speed = DW'(div); set_speed = 1'b1;
        step(); vecs++;
        if (dut_vec !== exp_vec()) begin
            errs++; $display("FAIL set_speed(%0d): got %b want %b", div, dut_vec, exp_vec());
        end
        set_speed = 1'b0;
        tx_valid = 1'b1; tx_data = b;
        step(); vecs++;
        if (dut_vec !== exp_vec()) begin
            errs++; $display("FAIL push %h: got %b want %b", b, dut_vec, exp_vec());
        end
        tx_valid = 1'b0;
    endtask

    task automatic test_frame(input string name, input int div, input logic [7:0] b);
        int low_start, low_len;
        set_div_and_push(div, b);
        low_start = -1; low_len = 0;
        for (int w = 0; w < 10 * div + 4; w++) begin
            step(); vecs++;
            if (dut_vec !== exp_vec()) begin
                errs++; $display("FAIL %s cyc%0d: got %b want %b", name, w, dut_vec, exp_vec());
            end
            if (low_start < 0 && tx === 1'b0) low_start = w;
        end
        // Start bit must begin on the first cycle after the push edge.
        vecs++;
        if (low_start !== 0) begin
            errs++; $display("FAIL %s start_latency: got %0d want 0", name, low_start);
        end
    endtask

    task automatic test_fifo_fill();
        speed = 13'd4; set_speed = 1'b1;
        step(); vecs++;
        if (dut_vec !== exp_vec()) begin
            errs++; $display("FAIL fill set_speed: got %b want %b", dut_vec, exp_vec());
        end
        set_speed = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tx_valid = 1'b1; tx_data = 8'(i + 1);
            for (int w = 0; w < 100; w++) begin
                step(); vecs++;
                if (dut_vec !== exp_vec()) begin
                    errs++; $display("FAIL fill push%0d: got %b want %b", i, dut_vec, exp_vec());
                end
                if (m_acc) break;
            end
            if (!m_acc) begin
                errs++; vecs++; $display("FAIL fill push%0d timeout: got not accepted want accepted", i);
            end
        end
        tx_valid = 1'b0;
        for (int w = 0; w < 250 && (m_act || mq.size() != 0); w++) begin
            step(); vecs++;
            if (dut_vec !== exp_vec()) begin
                errs++; $display("FAIL fill drain cyc%0d: got %b want %b", w, dut_vec, exp_vec());
            end
        end
        step(); vecs++;
        if (dut_vec !== exp_vec()) begin
            errs++; $display("FAIL fill idle: got %b want %b", dut_vec, exp_vec());
        end
    endtask

    task automatic test_speed_change();
        set_div_and_push(4, 8'h3C);
        tx_valid = 1'b1; tx_data = 8'hC3;
        step(); vecs++;
        if (dut_vec !== exp_vec()) begin
            errs++; $display("FAIL spd push2: got %b want %b", dut_vec, exp_vec());
        end
        tx_valid = 1'b0;
        for (int w = 0; w < 250 && (m_act || mq.size() != 0); w++) begin
            // Program the slower rate while the first frame is in its data bits.
            set_speed = (m_act && m_t == 14);
            speed     = 13'd8;
            step(); vecs++;
            if (dut_vec !== exp_vec()) begin
                errs++; $display("FAIL spd cyc%0d: got %b want %b", w, dut_vec, exp_vec());
            end
        end
        set_speed = 1'b0;
        vecs++;
        if (m_div !== 8) begin
            errs++; $display("FAIL spd second_div: got %0d want 8", m_div);
        end
    endtask

    task automatic test_reset_mid();
        set_div_and_push(4, 8'hFF);
        for (int i = 0; i < 2; i++) begin
            tx_valid = 1'b1; tx_data = 8'hA0 + 8'(i);
            step(); vecs++;
            if (dut_vec !== exp_vec()) begin
                errs++; $display("FAIL rstmid push%0d: got %b want %b", i, dut_vec, exp_vec());
            end
        end
        tx_valid = 1'b0;
        // Bit 3 occupies frame slot 4, cycles 16..19 at DIV=4.
        for (int w = 0; w < 40 && m_t != 17; w++) begin
            step(); vecs++;
            if (dut_vec !== exp_vec()) begin
                errs++; $display("FAIL rstmid run%0d: got %b want %b", w, dut_vec, exp_vec());
            end
        end
        reset = 1'b1;
        step(); vecs++;
        if (dut_vec !== 6'b110000) begin
            errs++; $display("FAIL rstmid abort: got %b want %b", dut_vec, 6'b110000);
        end
        reset = 1'b0;
        for (int w = 0; w < 60; w++) begin
            step(); vecs++;
            if (dut_vec !== exp_vec()) begin
                errs++; $display("FAIL rstmid after%0d: got %b want %b", w, dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_random();
        for (int w = 0; w < 1500; w++) begin
            tx_valid  = 1'($urandom_range(0, 1));
            tx_data   = 8'($urandom);
            set_speed = ($urandom_range(0, 19) == 0);
            speed     = DW'($urandom_range(0, 6));
            step(); vecs++;
            if (dut_vec !== exp_vec()) begin
                errs++; $display("FAIL rand cyc%0d: got %b want %b", w, dut_vec, exp_vec());
            end
        end
        tx_valid = 1'b0; set_speed = 1'b0;
        for (int w = 0; w < 400 && (m_act || mq.size() != 0); w++) begin
            step(); vecs++;
            if (dut_vec !== exp_vec()) begin
                errs++; $display("FAIL rand drain%0d: got %b want %b", w, dut_vec, exp_vec());
            end
        end
        vecs++;
        if (busy !== 1'b0) begin
            errs++; $display("FAIL rand final_busy: got %b want 0", busy);
        end
    endtask

    initial begin
        test_reset();
        test_frame("single", 4, 8'hA5);
        test_fifo_fill();
        test_speed_change();
        test_reset_mid();
        test_frame("clamp", 0, 8'h00);
        test_frame("div3", 3, 8'h96);
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
